// File: rtl/aoi211_bist_if.sv
// -----------------------------------------------------------------------------
// aoi211_bist_if
//
// Groups the control/status and cell-under-test signals of the AOI211 BIST
// block into one bundle.
//
//   master : the BIST engine (drives the cell inputs and the status outputs)
//   slave  : its environment (issues START, supplies the cell's ZN output)
//
// Signals
//   start       run request, accepted only while the engine is idle
//   zn          ZN output of the cell under test
//   a,b,c1,c2   registered drive to the cell under test
//   busy        high while a run is in progress
//   done        one-cycle pulse at run end
//   pass        last run had zero mismatches
//   err_cnt     saturating mismatch count (CNT_W bits)
//   fail_seen   at least one mismatch in the last/current run
//   first_fail  vector index of the first mismatch (valid when fail_seen=1)
//   fault_inj   fault-injection request; exists only when AOI211_BIST_INJECT_EN
//               is defined
//
// Handshake: start is a level request sampled on every rising clock edge; it
// is acted on only in the idle state and ignored otherwise (no queueing).
// Completion is signalled by a single-cycle done pulse; the result fields are
// stable from that cycle until the next accepted start.
// -----------------------------------------------------------------------------
interface aoi211_bist_if #(
   parameter int CNT_W = 5
);
   logic             start;
   logic             zn;
   logic             a;
   logic             b;
   logic             c1;
   logic             c2;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] err_cnt;
   logic             fail_seen;
   logic [3:0]       first_fail;

`ifdef AOI211_BIST_INJECT_EN
   logic             fault_inj;

   modport master (
      input  start, zn, fault_inj,
      output a, b, c1, c2, busy, done, pass, err_cnt, fail_seen, first_fail
   );

   modport slave (
      output start, zn, fault_inj,
      input  a, b, c1, c2, busy, done, pass, err_cnt, fail_seen, first_fail
   );
`else
   modport master (
      input  start, zn,
      output a, b, c1, c2, busy, done, pass, err_cnt, fail_seen, first_fail
   );

   modport slave (
      output start, zn,
      input  a, b, c1, c2, busy, done, pass, err_cnt, fail_seen, first_fail
   );
`endif
endinterface

// File: rtl/aoi211_bist.sv
// -----------------------------------------------------------------------------
// aoi211_bist
//
// Built-in self-test engine for one AOI211 cell (ZN = ~(A | B | (C1 & C2))).
// On an accepted start it walks all 16 input vectors idx = {A,B,C1,C2},
// holds each for SETTLE+1 cycles, samples ZN on the last cycle of the dwell
// window and compares it with the value expected from the registered drive
// bits. Results: pass/fail, saturating mismatch count, first failing vector.
//
// Parameters
//   SETTLE  extra dwell cycles per vector before sampling, legal 0..15
//   CNT_W   width of the mismatch counter, minimum 1
//
// Ports
//   i_ck     clock, rising edge
//   i_rn     asynchronous active-low reset
//   io_bus   aoi211_bist_if.master (start/zn in, cell drive and status out)
//   o_state  debug view of the FSM state (0 IDLE, 1 RUN, 2 FIN)
//
// Optional feature: define AOI211_BIST_INJECT_EN to add the fault_inj input.
// Its value is latched on an accepted start; when latched high, the sampled
// ZN is inverted for vector 5 only, forcing exactly one mismatch on a good
// cell so the checker itself can be proven.
// -----------------------------------------------------------------------------
module aoi211_bist #(
   parameter int SETTLE = 2,
   parameter int CNT_W  = 5
) (
   input  logic                 i_ck,
   input  logic                 i_rn,
   aoi211_bist_if.master        io_bus,
   output logic [1:0]           o_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   localparam logic [3:0]       SETTLE_V = 4'(SETTLE);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [3:0]       IDX_LAST = 4'd15;

   // ---------------------------------------------------------------------
   // State and result registers
   // ---------------------------------------------------------------------
   state_t           r_state;
   logic [3:0]       r_idx;
   logic [3:0]       r_dwell;
   logic [3:0]       r_drv;        // {A, B, C1, C2} as presented to the cell
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [CNT_W-1:0] r_err_cnt;
   logic             r_fail_seen;
   logic [3:0]       r_first_fail;

   state_t           w_state_nxt;
   logic [3:0]       w_idx_nxt;
   logic [3:0]       w_dwell_nxt;
   logic [3:0]       w_drv_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_pass_nxt;
   logic [CNT_W-1:0] w_err_cnt_nxt;
   logic             w_fail_seen_nxt;
   logic [3:0]       w_first_fail_nxt;

   logic             w_exp_zn;
   logic             w_zn_eff;
   logic             w_miss;
   logic             w_sample;

   // ---------------------------------------------------------------------
   // Compare path
   // ---------------------------------------------------------------------
   // Expected value comes from the registered drive bits, so it always
   // matches what the cell actually sees during the dwell window.
   assign w_exp_zn = ~(r_drv[3] | r_drv[2] | (r_drv[1] & r_drv[0]));

`ifdef AOI211_BIST_INJECT_EN
   logic r_inj;
   logic w_inj_nxt;

   // Inverting only vector 5 yields exactly one forced mismatch on a good cell.
   assign w_zn_eff = io_bus.zn ^ (r_inj & (r_idx == 4'd5));
`else
   assign w_zn_eff = io_bus.zn;
`endif

   assign w_miss   = (w_zn_eff != w_exp_zn);
   assign w_sample = (r_state == S_RUN) && (r_dwell == SETTLE_V);

   // ---------------------------------------------------------------------
   // Next-state / next-value logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt      = r_state;
      w_idx_nxt        = r_idx;
      w_dwell_nxt      = r_dwell;
      w_drv_nxt        = r_drv;
      w_busy_nxt       = r_busy;
      w_done_nxt       = 1'b0;
      w_pass_nxt       = r_pass;
      w_err_cnt_nxt    = r_err_cnt;
      w_fail_seen_nxt  = r_fail_seen;
      w_first_fail_nxt = r_first_fail;
`ifdef AOI211_BIST_INJECT_EN
      w_inj_nxt        = r_inj;
`endif

      case (r_state)
         S_IDLE: begin
            w_drv_nxt  = 4'd0;
            w_busy_nxt = 1'b0;
            if (io_bus.start) begin
               w_state_nxt      = S_RUN;
               w_idx_nxt        = 4'd0;
               w_drv_nxt        = 4'd0;
               w_dwell_nxt      = 4'd0;
               w_err_cnt_nxt    = '0;
               w_fail_seen_nxt  = 1'b0;
               w_first_fail_nxt = 4'd0;
               w_pass_nxt       = 1'b0;
               w_busy_nxt       = 1'b1;
`ifdef AOI211_BIST_INJECT_EN
               w_inj_nxt        = io_bus.fault_inj;
`endif
            end
         end

         S_RUN: begin
            if (!w_sample) begin
               w_dwell_nxt = r_dwell + 4'd1;
            end else begin
               if (w_miss) begin
                  if (r_err_cnt != CNT_MAX) begin
                     w_err_cnt_nxt = r_err_cnt + 1'b1;
                  end
                  if (!r_fail_seen) begin
                     w_fail_seen_nxt  = 1'b1;
                     w_first_fail_nxt = r_idx;
                  end
               end

               if (r_idx != IDX_LAST) begin
                  w_idx_nxt   = r_idx + 4'd1;
                  w_drv_nxt   = r_idx + 4'd1;
                  w_dwell_nxt = 4'd0;
               end else begin
                  // Last vector: verdict must include this final sample.
                  w_state_nxt = S_FIN;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                  w_drv_nxt   = 4'd0;
                  w_dwell_nxt = 4'd0;
                  w_idx_nxt   = 4'd0;
                  w_pass_nxt  = ~(r_fail_seen | w_miss);
               end
            end
         end

         S_FIN: begin
            // Start is deliberately not looked at here; a request held across
            // the run end is only accepted once IDLE is re-entered.
            w_state_nxt = S_IDLE;
            w_drv_nxt   = 4'd0;
            w_busy_nxt  = 1'b0;
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_drv_nxt   = 4'd0;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge i_ck or negedge i_rn) begin
      if (!i_rn) begin
         r_state      <= S_IDLE;
         r_idx        <= 4'd0;
         r_dwell      <= 4'd0;
         r_drv        <= 4'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_pass       <= 1'b0;
         r_err_cnt    <= '0;
         r_fail_seen  <= 1'b0;
         r_first_fail <= 4'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_idx        <= w_idx_nxt;
         r_dwell      <= w_dwell_nxt;
         r_drv        <= w_drv_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_pass       <= w_pass_nxt;
         r_err_cnt    <= w_err_cnt_nxt;
         r_fail_seen  <= w_fail_seen_nxt;
         r_first_fail <= w_first_fail_nxt;
      end
   end

`ifdef AOI211_BIST_INJECT_EN
   always_ff @(posedge i_ck or negedge i_rn) begin
      if (!i_rn) begin
         r_inj <= 1'b0;
      end else begin
         r_inj <= w_inj_nxt;
      end
   end
`endif

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign io_bus.a          = r_drv[3];
   assign io_bus.b          = r_drv[2];
   assign io_bus.c1         = r_drv[1];
   assign io_bus.c2         = r_drv[0];
   assign io_bus.busy       = r_busy;
   assign io_bus.done       = r_done;
   assign io_bus.pass       = r_pass;
   assign io_bus.err_cnt    = r_err_cnt;
   assign io_bus.fail_seen  = r_fail_seen;
   assign io_bus.first_fail = r_first_fail;

   assign o_state = r_state;

endmodule

// File: tb/tb_aoi211_bist.sv
// -----------------------------------------------------------------------------
// tb_aoi211_bist
//
// Directed bench for aoi211_bist. dut0 (SETTLE=2, CNT_W=5) faces a cell model
// that can be good, stuck-at-0 or stuck-at-1. dut1 (SETTLE=0, CNT_W=2) faces
// a stuck-at-1 cell to exercise counter saturation with the shortest dwell.
// Fault injection is exercised when AOI211_BIST_INJECT_EN is defined.
// -----------------------------------------------------------------------------
module tb_aoi211_bist;

   // ---------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------
   logic       ck = 1'b0;
   logic       rn;
   logic [1:0] state0;
   logic [1:0] state1;
   int         mode;          // cell model for dut0: 0 good, 1 ZN=0, 2 ZN=1
   int         n_vec  = 0;
   int         n_miss = 0;

   always #5 ck = ~ck;

   aoi211_bist_if #(.CNT_W(5)) bus0 ();
   aoi211_bist_if #(.CNT_W(2)) bus1 ();

   aoi211_bist #(.SETTLE(2), .CNT_W(5)) dut0 (
      .i_ck    (ck),
      .i_rn    (rn),
      .io_bus  (bus0),
      .o_state (state0)
   );

   aoi211_bist #(.SETTLE(0), .CNT_W(2)) dut1 (
      .i_ck    (ck),
      .i_rn    (rn),
      .io_bus  (bus1),
      .o_state (state1)
   );

   // Cell under test models
   assign bus0.zn = (mode == 1) ? 1'b0 :
                    (mode == 2) ? 1'b1 :
                    ~(bus0.a | bus0.b | (bus0.c1 & bus0.c2));
   assign bus1.zn = 1'b1;

   // ---------------------------------------------------------------------
   // Checker
   // ---------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Driver tasks (entered and left at #1 after a rising edge)
   // ---------------------------------------------------------------------
   // One full run on dut0. With hold=1, start stays high (with short drops to
   // re-pulse it) throughout and is left high at exit.
   task automatic run0(input int md, input bit hold, input int e_pass,
                       input int e_cnt, input int e_fs, input int e_ff);
      mode = md;
      bus0.start = 1'b1;
      @(posedge ck); #1;                      // accepted at this edge (E0)
      for (int n = 0; n < 48; n++) begin
         bus0.start = hold ? ((n % 5) != 2) : 1'b0;
         check("run0_busy", bus0.busy, 1);
         check("run0_done_low", bus0.done, 0);
         check("run0_drive", {bus0.a, bus0.b, bus0.c1, bus0.c2}, n / 3);
         @(posedge ck); #1;
      end
      // E0+48: FIN cycle
      check("fin_done", bus0.done, 1);
      check("fin_busy", bus0.busy, 0);
      check("fin_drive", {bus0.a, bus0.b, bus0.c1, bus0.c2}, 0);
      check("fin_state", state0, 2);
      check("fin_pass", bus0.pass, e_pass);
      check("fin_err_cnt", bus0.err_cnt, e_cnt);
      check("fin_fail_seen", bus0.fail_seen, e_fs);
      check("fin_first_fail", bus0.first_fail, e_ff);
      bus0.start = hold;
      @(posedge ck); #1;
      // E0+49: back in IDLE, results held, start seen in FIN was ignored
      check("idle_done", bus0.done, 0);
      check("idle_busy", bus0.busy, 0);
      check("idle_state", state0, 0);
      check("idle_pass", bus0.pass, e_pass);
      check("idle_err_cnt", bus0.err_cnt, e_cnt);
   endtask

   task automatic run1_sat();
      bus1.start = 1'b1;
      @(posedge ck); #1;
      bus1.start = 1'b0;
      for (int n = 0; n < 16; n++) begin
         check("run1_busy", bus1.busy, 1);
         check("run1_drive", {bus1.a, bus1.b, bus1.c1, bus1.c2}, n);
         @(posedge ck); #1;
      end
      check("sat_done", bus1.done, 1);
      check("sat_err_cnt", bus1.err_cnt, 3);
      check("sat_fail_seen", bus1.fail_seen, 1);
      check("sat_first_fail", bus1.first_fail, 3);
      check("sat_pass", bus1.pass, 0);
      @(posedge ck); #1;
      check("sat_idle", state1, 0);
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      rn         = 1'b0;
      mode       = 0;
      bus0.start = 1'b0;
      bus1.start = 1'b0;
`ifdef AOI211_BIST_INJECT_EN
      bus0.fault_inj = 1'b0;
      bus1.fault_inj = 1'b0;
`endif
      repeat (3) @(posedge ck);
      #1;
      check("rst_state", state0, 0);
      check("rst_drive", {bus0.a, bus0.b, bus0.c1, bus0.c2}, 0);
      check("rst_busy", bus0.busy, 0);
      check("rst_done", bus0.done, 0);
      check("rst_pass", bus0.pass, 0);
      check("rst_err_cnt", bus0.err_cnt, 0);
      check("rst_fail_seen", bus0.fail_seen, 0);
      check("rst_first_fail", bus0.first_fail, 0);
      rn = 1'b1;
      @(posedge ck); #1;

      // Good cell, stuck-at-0, stuck-at-1
      run0(0, 1'b0, 1, 0, 0, 0);
      run0(1, 1'b0, 0, 3, 1, 0);
      run0(2, 1'b0, 0, 13, 1, 3);

      // Start held/re-pulsed across a whole run; the second run starts at the
      // first edge after IDLE is re-entered and is checked cycle-exactly.
      run0(0, 1'b1, 1, 0, 0, 0);
      run0(0, 1'b0, 1, 0, 0, 0);

      // Asynchronous reset at idx=7 of a stuck-at-1 run
      mode = 2;
      bus0.start = 1'b1;
      @(posedge ck); #1;
      bus0.start = 1'b0;
      for (int n = 0; n < 22; n++) begin
         @(posedge ck); #1;
      end
      check("pre_rst_drive", {bus0.a, bus0.b, bus0.c1, bus0.c2}, 7);
      check("pre_rst_err_cnt", bus0.err_cnt, 4);
      check("pre_rst_first_fail", bus0.first_fail, 3);
      rn = 1'b0;
      #1;
      check("arst_state", state0, 0);
      check("arst_drive", {bus0.a, bus0.b, bus0.c1, bus0.c2}, 0);
      check("arst_busy", bus0.busy, 0);
      check("arst_err_cnt", bus0.err_cnt, 0);
      check("arst_fail_seen", bus0.fail_seen, 0);
      check("arst_first_fail", bus0.first_fail, 0);
      @(posedge ck); #1;
      check("arst_done", bus0.done, 0);
      rn = 1'b1;
      @(posedge ck); #1;
      run0(0, 1'b0, 1, 0, 0, 0);

      // Saturating counter with minimal dwell
      run1_sat();

`ifdef AOI211_BIST_INJECT_EN
      bus0.fault_inj = 1'b1;
      run0(0, 1'b0, 0, 1, 1, 5);
      bus0.fault_inj = 1'b0;
      run0(0, 1'b0, 1, 0, 0, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
